// File: rtl/neuron_stream_feeder.sv
// rtl/neuron_stream_feeder.sv - operand sequencer replaying (A[i], B[i]) pairs into NeuronCore
//
// Holds two operand memories (A = input vector, B = weights) loaded through a
// write port that is only open while idle. On go_i it replays len pairs on
// stream_a_o/stream_b_o, each held HOLD cycles, with start_o qualifying them
// and done_o pulsing once at the end of the pass.
//
// Optional feature macro: FEEDER_LOOP_EN
//   When defined, go_i high on the last hold cycle of the last pair restarts the
//   stream at index 0 with no gap (done_o pulses, start_o and busy_o stay high).
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   wr_en_i     memory write strobe (ignored unless idle)
//   wr_sel_i    0 = write memory A, 1 = write memory B
//   wr_addr_i   write address
//   wr_data_i   write data
//   length_i    pairs per pass, clamped to WORDS, sampled with go_i
//   go_i        start request, sampled while idle
//   busy_o      high while a pass is in progress
//   done_o      one-cycle pulse at the end of a pass
//   start_o     high while a valid pair is on the stream
//   stream_a_o  input operand
//   stream_b_o  weight operand
//   elem_idx_o  index of the pair on the stream

module neuron_stream_feeder #(
   parameter int DWIDTH = 32,
   parameter int WORDS  = 4096,
   parameter int SIZE   = $clog2(WORDS),
   parameter int HOLD   = 10
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic              wr_sel_i,
   input  logic [SIZE-1:0]   wr_addr_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   input  logic [SIZE:0]     length_i,
   input  logic              go_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              start_o,
   output logic [DWIDTH-1:0] stream_a_o,
   output logic [DWIDTH-1:0] stream_b_o,
   output logic [SIZE-1:0]   elem_idx_o
);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_FINISH} state_e;

   localparam logic [SIZE:0] WORDS_L   = (SIZE+1)'(WORDS);
   localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);

   state_e            state_q;
   logic [SIZE:0]     len_q;
   logic [SIZE-1:0]   idx_q;
   logic [7:0]        hold_q;

   logic [DWIDTH-1:0] mem_a [WORDS];
   logic [DWIDTH-1:0] mem_b [WORDS];
   logic [DWIDTH-1:0] rd_a_q, rd_b_q;

   logic              busy_q, done_q, start_q;
   logic [DWIDTH-1:0] stream_a_q, stream_b_q;
   logic [SIZE-1:0]   elem_idx_q;

   logic              last_hold, last_pair, wrap, rd_en;
   logic [SIZE-1:0]   rd_addr;
   logic [SIZE:0]     len_d;

   always_comb begin
      last_hold = (hold_q == HOLD_LAST);
      // Compared one bit wider so len = WORDS ends at WORDS-1 without wrapping.
      last_pair = ({1'b0, idx_q} == (len_q - 1'b1));
      len_d     = (length_i > WORDS_L) ? WORDS_L : length_i;
      wrap      = 1'b0;
`ifdef FEEDER_LOOP_EN
      wrap      = (state_q == S_STREAM) && last_hold && last_pair && go_i;
`endif
      // Next pair is fetched on the last hold cycle so it lands with no bubble.
      rd_en     = (state_q == S_PRIME) ||
                  ((state_q == S_STREAM) && last_hold && (!last_pair || wrap));
      rd_addr   = ((state_q == S_STREAM) && !last_pair) ? idx_q + 1'b1 : '0;
   end

   // Operand memories: writes only while idle, 1-cycle synchronous read.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && (state_q == S_IDLE)) begin
         if (wr_sel_i) mem_b[wr_addr_i] <= wr_data_i;
         else          mem_a[wr_addr_i] <= wr_data_i;
      end
      if (rd_en) begin
         rd_a_q <= mem_a[rd_addr];
         rd_b_q <= mem_b[rd_addr];
      end
   end

   // Outputs are registered from the current state, so they trail it by one
   // cycle; this gives busy one cycle after GO and start two cycles after GO.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         hold_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
         stream_a_q <= '0;
         stream_b_q <= '0;
         elem_idx_q <= '0;
      end else begin
         busy_q     <= (state_q == S_PRIME) || (state_q == S_STREAM);
         start_q    <= (state_q == S_STREAM);
         done_q     <= (state_q == S_FINISH) || wrap;
         stream_a_q <= (state_q == S_STREAM) ? rd_a_q : '0;
         stream_b_q <= (state_q == S_STREAM) ? rd_b_q : '0;
         elem_idx_q <= (state_q == S_STREAM) ? idx_q  : '0;

         case (state_q)
            S_IDLE: begin
               if (go_i) begin
                  len_q   <= len_d;
                  idx_q   <= '0;
                  hold_q  <= '0;
                  state_q <= (len_d == '0) ? S_FINISH : S_PRIME;
               end
            end
            S_PRIME: state_q <= S_STREAM;
            S_STREAM: begin
               if (last_hold) begin
                  hold_q <= '0;
                  if (!last_pair)  idx_q   <= idx_q + 1'b1;
                  else if (wrap)   idx_q   <= '0;
                  else             state_q <= S_FINISH;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign start_o    = start_q;
   assign stream_a_o = stream_a_q;
   assign stream_b_o = stream_b_q;
   assign elem_idx_o = elem_idx_q;

endmodule

// File: tb/tb_neuron_stream_feeder.sv
// tb/tb_neuron_stream_feeder.sv - self-checking bench for neuron_stream_feeder
module tb_neuron_stream_feeder;

   localparam int DW    = 32;
   localparam int WORDS = 4096;
   localparam int SZ    = 12;
   localparam int HV [3] = '{10, 1, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic [2:0]     wr_en;
   logic [2:0]     go;
   logic           wr_sel;
   logic [SZ-1:0]  wr_addr;
   logic [DW-1:0]  wr_data;
   logic [SZ:0]    length;
   logic [2:0]     busy, done, start;
   logic [DW-1:0]  sa [3];
   logic [DW-1:0]  sb [3];
   logic [SZ-1:0]  idx [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      neuron_stream_feeder #(.DWIDTH(DW), .WORDS(WORDS), .SIZE(SZ), .HOLD(HV[g])) u_dut (
         .clk_i      (clk),
         .rst_ni     (rst_n),
         .wr_en_i    (wr_en[g]),
         .wr_sel_i   (wr_sel),
         .wr_addr_i  (wr_addr),
         .wr_data_i  (wr_data),
         .length_i   (length),
         .go_i       (go[g]),
         .busy_o     (busy[g]),
         .done_o     (done[g]),
         .start_o    (start[g]),
         .stream_a_o (sa[g]),
         .stream_b_o (sb[g]),
         .elem_idx_o (idx[g])
      );
   end

   logic [DW-1:0] ma [WORDS];
   logic [DW-1:0] mb [WORDS];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_word(input bit sel, input int addr, input logic [DW-1:0] data);
      @(negedge clk);
      wr_en   = 3'b111;
      wr_sel  = sel;
      wr_addr = SZ'(addr);
      wr_data = data;
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
      @(negedge clk);
      wr_en = 3'b000;
   endtask

   // Runs one pass and compares every cycle against the expected waveform
   // derived from len, HOLD and the model memories.
   task automatic run_pass(input int d, input int len_in, input int inj,
                           output int st_cnt, output int first_st, output int done_cyc,
                           output int last_idx, output logic [DW-1:0] a_at1);
      int H, L, n_end, k, bad, bad_n;
      logic e_busy, e_start, e_done;
      logic [DW-1:0] e_a, e_b;
      logic [SZ-1:0] e_idx;
      logic [DW-1:0] bad_a, bad_ea;
      H = HV[d];
      L = (len_in > WORDS) ? WORDS : len_in;
      n_end = L * H + 3;
      st_cnt = 0; first_st = -1; done_cyc = -1; last_idx = -1; a_at1 = '0;
      bad = 0; bad_n = -1; bad_a = '0; bad_ea = '0;
      @(negedge clk);
      length = (SZ+1)'(len_in);
      go[d]  = 1'b1;
      for (int n = 0; n <= n_end; n++) begin
         @(negedge clk);
         e_busy  = (L > 0) && (n >= 1) && (n <= L * H + 1);
         e_start = (L > 0) && (n >= 2) && (n <= L * H + 1);
         e_done  = (L == 0) ? (n == 1) : (n == L * H + 2);
         k       = e_start ? (n - 2) / H : 0;
         e_a     = e_start ? ma[k] : '0;
         e_b     = e_start ? mb[k] : '0;
         e_idx   = SZ'(k);
         if ({busy[d], start[d], done[d], sa[d], sb[d], idx[d]} !==
             {e_busy, e_start, e_done, e_a, e_b, e_idx}) begin
            if (bad == 0) begin bad_n = n; bad_a = sa[d]; bad_ea = e_a; end
            bad++;
         end
         if (start[d]) begin
            st_cnt++;
            if (first_st < 0) first_st = n;
            last_idx = int'(idx[d]);
            if (idx[d] == 1) a_at1 = sa[d];
         end
         if (done[d] && done_cyc < 0) done_cyc = n;
         if (n == 0) go[d] = 1'b0;
         if (n == inj) begin
            wr_en[d] = 1'b1; wr_sel = 1'b0; wr_addr = 1; wr_data = '0; go[d] = 1'b1;
         end
         if (n == inj + 1) begin
            wr_en[d] = 1'b0; go[d] = 1'b0;
         end
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL trace dut%0d len%0d: %0d bad cycles, first cycle %0d stream_a got %h expected %h",
                  d, len_in, bad, bad_n, bad_a, bad_ea);
      end
   endtask

   typedef struct {
      int d; int len; int inj;
      int e_cnt; int e_first; int e_done; int e_last; logic [DW-1:0] e_a1;
   } vec_t;

   initial begin
      vec_t tbl [10];
      int cnt, fst, dc, li, d, len;
      logic [DW-1:0] a1;
      bit seen_done;

      tbl[0] = '{0, 3,    -1, 30,   2, 32,   2,    32'h40000000};
      tbl[1] = '{0, 0,    -1, 0,   -1, 1,   -1,    32'h0};
      tbl[2] = '{0, 3,    15, 30,   2, 32,   2,    32'h40000000};
      tbl[3] = '{0, 3,    -1, 30,   2, 32,   2,    32'h40000000};
      tbl[4] = '{1, 4096, -1, 4096, 2, 4098, 4095, 32'h40000000};
      tbl[5] = '{1, 5000, -1, 4096, 2, 4098, 4095, 32'h40000000};
      tbl[6] = '{2, 2,    -1, 6,    2, 8,    1,    32'h40000000};
      tbl[7] = '{0, 1,    -1, 10,   2, 12,   0,    32'h0};
      tbl[8] = '{1, 1,    -1, 1,    2, 3,    0,    32'h0};
      tbl[9] = '{1, 2,    -1, 2,    2, 4,    1,    32'h40000000};

      rst_n = 1'b0; wr_en = '0; go = '0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; length = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {busy, done, start, sa[0], sa[1], sa[2], idx[0], idx[2]}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {busy, done, start, sb[0], sb[1], idx[1]}, '0);

      // Fill both memories with random words, then overlay the known operands.
      for (int i = 0; i < WORDS; i++) begin
         for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            wr_en = 3'b111; wr_sel = s[0]; wr_addr = SZ'(i); wr_data = $urandom;
            if (s == 0) ma[i] = wr_data; else mb[i] = wr_data;
         end
      end
      @(negedge clk);
      wr_en = 3'b000;
      write_word(0, 0, 32'h3F800000);
      write_word(0, 1, 32'h40000000);
      write_word(0, 2, 32'h40400000);
      for (int i = 0; i < 3; i++) write_word(1, i, 32'h40000000);

      for (int t = 0; t < 10; t++) begin
         run_pass(tbl[t].d, tbl[t].len, tbl[t].inj, cnt, fst, dc, li, a1);
         check($sformatf("row%0d_start_count", t), cnt, tbl[t].e_cnt);
         check($sformatf("row%0d_first_start", t), fst, tbl[t].e_first);
         check($sformatf("row%0d_done_cycle", t), dc, tbl[t].e_done);
         check($sformatf("row%0d_last_idx", t), li, tbl[t].e_last);
         check($sformatf("row%0d_a_at_idx1", t), a1, tbl[t].e_a1);
      end

      // Reset dropped while index 1 is on the stream aborts the pass.
      @(negedge clk);
      length = 3; go[0] = 1'b1;
      @(negedge clk);
      go[0] = 1'b0;
      repeat (15) @(negedge clk);
      check("abort_pre_idx", idx[0], 1);
      check("abort_pre_a", sa[0], 32'h40000000);
      rst_n = 1'b0;
      #1;
      check("abort_outputs_zero", {busy[0], start[0], done[0], sa[0], sb[0], idx[0]}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done[0] || busy[0] || start[0]) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);
      run_pass(0, 3, -1, cnt, fst, dc, li, a1);
      check("replay_start_count", cnt, 30);
      check("replay_done_cycle", dc, 32);

      // Random passes over freshly rewritten words.
      for (int r = 0; r < 6; r++) begin
         for (int w = 0; w < 3; w++)
            write_word($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom);
         d   = $urandom_range(0, 2);
         len = $urandom_range(1, 12);
         run_pass(d, len, -1, cnt, fst, dc, li, a1);
         check($sformatf("rand%0d_start_count", r), cnt, len * HV[d]);
         check($sformatf("rand%0d_last_idx", r), li, len - 1);
      end

`ifdef FEEDER_LOOP_EN
      begin
         int bad, k;
         logic e_busy, e_start, e_done;
         logic [DW-1:0] e_a;
         bad = 0;
         @(negedge clk);
         length = 2; go[2] = 1'b1;
         for (int n = 0; n <= 22; n++) begin
            @(negedge clk);
            e_start = (n >= 2) && (n <= 19);
            e_busy  = (n >= 1) && (n <= 19);
            e_done  = (n == 7) || (n == 13) || (n == 20);
            k       = e_start ? ((n - 2) / 3) % 2 : 0;
            e_a     = e_start ? ma[k] : '0;
            if ({busy[2], start[2], done[2], sa[2], idx[2]} !== {e_busy, e_start, e_done, e_a, SZ'(k)})
               bad++;
            if (n == 14) go[2] = 1'b0;
         end
         check("loop_trace_bad_cycles", bad, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
